mem_fifo_loader: RTL and testbench

MEM_FIFO_LOADER -- requirements
Module: mem_fifo_loader

---
 rtl/mem_fifo_loader.sv | 173 +++++++++++++++++
 tb/tb_mem_fifo_loader.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_fifo_loader.sv
// mem_fifo_loader: reads NUM_FIFOS*WPF consecutive memory words starting at
// base_addr and unpacks each word, least-significant entry first, into a bank
// of FIFOs. Each FIFO receives exactly DEPTH entries; surplus entries in the
// last word of a FIFO are dropped.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; done reports the last completed fill
// REQ    | mem_read asserted, address held until the memory accepts
// WAIT   | read accepted, waiting for mem_readdatavalid
// UNPACK | writing entries from the shift register into FIFO fifo_q
// DRAIN  | aborted with a read in flight; swallow the response, then IDLE
module mem_fifo_loader #(
   parameter int NUM_FIFOS  = 9,
   parameter int DEPTH      = 8,
   parameter int DATA_WIDTH = 8,
   parameter int WORD_WIDTH = 64,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_read,
   input  logic                  mem_waitrequest,
   input  logic [WORD_WIDTH-1:0] mem_readdata,
   input  logic                  mem_readdatavalid,
   input  logic [NUM_FIFOS-1:0]  fifo_full,
   output logic [DATA_WIDTH-1:0] fifo_data,
   output logic [NUM_FIFOS-1:0]  fifo_wr,
   output logic                  busy,
   output logic                  done
);

   localparam int BPW    = WORD_WIDTH / DATA_WIDTH;
   localparam int WPF    = (DEPTH + BPW - 1) / BPW;
   localparam int FIFO_W = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1;
   localparam int WORD_W = (WPF > 1) ? $clog2(WPF) : 1;
   localparam int ENT_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int BYTE_W = (BPW > 1) ? $clog2(BPW) : 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_REQ    = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_UNPACK = 3'd3;
   localparam logic [2:0] S_DRAIN  = 3'd4;

   logic [2:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [FIFO_W-1:0]     fifo_q, fifo_d;
   logic [WORD_W-1:0]     word_q, word_d;
   logic [ENT_W-1:0]      ent_q, ent_d;
   logic [BYTE_W-1:0]     byte_q, byte_d;
   logic [WORD_WIDTH-1:0] shift_q, shift_d;
   logic                  done_q, done_d;
   logic                  wr_ok;

   // A write happens only in UNPACK, into a non-full FIFO, and never in the
   // cycle an abort is taken so that aborted fills leave no partial entry.
   assign wr_ok = (state_q == S_UNPACK) && !fifo_full[fifo_q] && !abort;

   assign mem_read    = (state_q == S_REQ);
   assign mem_address = base_q + ADDR_WIDTH'(fifo_q) * ADDR_WIDTH'(WPF) + ADDR_WIDTH'(word_q);
   assign fifo_data   = shift_q[DATA_WIDTH-1:0];
   assign fifo_wr     = wr_ok ? (NUM_FIFOS'(1) << fifo_q) : '0;
   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;

   // Next-state and counter update logic.
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      fifo_d  = fifo_q;
      word_d  = word_q;
      ent_d   = ent_q;
      byte_d  = byte_q;
      shift_d = shift_q;
      done_d  = done_q;
      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               done_d  = 1'b0;
               base_d  = base_addr;
               fifo_d  = '0;
               word_d  = '0;
               ent_d   = '0;
               byte_d  = '0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            // mem_read is always high here, so acceptance is just !waitrequest.
            if (!mem_waitrequest) begin
               state_d = abort ? S_DRAIN : S_WAIT;
            end else if (abort) begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (mem_readdatavalid) begin
               if (abort) begin
                  state_d = S_IDLE;
               end else begin
                  shift_d = mem_readdata;
                  state_d = S_UNPACK;
               end
            end else if (abort) begin
               state_d = S_DRAIN;
            end
         end
         S_UNPACK: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (wr_ok) begin
               shift_d = shift_q >> DATA_WIDTH;
               if (ent_q == ENT_W'(DEPTH - 1)) begin
                  ent_d  = '0;
                  byte_d = '0;
                  word_d = '0;
                  if (fifo_q == FIFO_W'(NUM_FIFOS - 1)) begin
                     done_d  = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     fifo_d  = fifo_q + FIFO_W'(1);
                     state_d = S_REQ;
                  end
               end else begin
                  ent_d = ent_q + ENT_W'(1);
                  if (byte_q == BYTE_W'(BPW - 1)) begin
                     byte_d  = '0;
                     word_d  = word_q + WORD_W'(1);
                     state_d = S_REQ;
                  end else begin
                     byte_d = byte_q + BYTE_W'(1);
                  end
               end
            end
         end
         S_DRAIN: begin
            if (mem_readdatavalid) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, counters and shift register; reset clears everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         fifo_q  <= '0;
         word_q  <= '0;
         ent_q   <= '0;
         byte_q  <= '0;
         shift_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         fifo_q  <= fifo_d;
         word_q  <= word_d;
         ent_q   <= ent_d;
         byte_q  <= byte_d;
         shift_q <= shift_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_mem_fifo_loader.sv
// Bench for mem_fifo_loader: a default-parameter instance (A) with a latency-2
// memory model, and a DEPTH=12/NUM_FIFOS=2 instance (B) for partial-word cases.
module tb_mem_fifo_loader;

   typedef struct {
      int         idx;
      logic [7:0] data;
   } wr_t;

   typedef struct {
      logic [31:0] base;
      int          stall_fifo;
      int          stall_n;
      int          exp_writes;
      logic        exp_done;
   } vec_t;

   int checks = 0;
   int errors = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // ---------------- instance A (defaults) ----------------
   logic        start, abort, waitreq, stray_v, mvalid_a, rvalid;
   logic [31:0] base_addr, mem_address, mbase_a, paddr_a;
   logic        mem_read;
   logic [63:0] rdata;
   logic [8:0]  fifo_full, fifo_wr;
   logic [7:0]  fifo_data;
   logic        busy, done;
   logic [1:0]  lat_a;

   wr_t         exp_wr_a[$];
   logic [31:0] exp_addr_a[$];
   int          nwr_a;
   logic [7:0]  first0, last8;
   bit          seen0;

   assign rvalid = mvalid_a | stray_v;

   mem_fifo_loader dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .base_addr(base_addr),
      .mem_address(mem_address), .mem_read(mem_read), .mem_waitrequest(waitreq),
      .mem_readdata(rdata), .mem_readdatavalid(rvalid), .fifo_full(fifo_full),
      .fifo_data(fifo_data), .fifo_wr(fifo_wr), .busy(busy), .done(done)
   );

   // ---------------- instance B (DEPTH=12, NUM_FIFOS=2) ----------------
   logic        start_b, abort_b, mvalid_b;
   logic [31:0] base_b, addr_b, mbase_b, paddr_b;
   logic        read_b;
   logic [63:0] rdata_b;
   logic [1:0]  full_b, wr_b;
   logic [7:0]  data_b;
   logic        busy_b, done_b;
   logic [1:0]  lat_b;
   wr_t         exp_wr_b[$];
   logic [31:0] exp_addr_b[$];
   int          nwr_b;

   mem_fifo_loader #(.NUM_FIFOS(2), .DEPTH(12)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .base_addr(base_b),
      .mem_address(addr_b), .mem_read(read_b), .mem_waitrequest(1'b0),
      .mem_readdata(rdata_b), .mem_readdatavalid(mvalid_b), .fifo_full(full_b),
      .fifo_data(data_b), .fifo_wr(wr_b), .busy(busy_b), .done(done_b)
   );

   function automatic logic [63:0] word_of(input logic [31:0] off);
      return 64'h0807060504030201 + {32'd0, off} * 64'h0808080808080808;
   endfunction

   function automatic logic [7:0] exp_byte(input int k, input int e, input int wpf, input int bpw);
      logic [63:0] w;
      w = word_of(32'(k * wpf + e / bpw));
      return w[8*(e%bpw) +: 8];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Memory model A: accepts when mem_read && !waitreq, answers 2 cycles later.
   always @(posedge clk) begin
      mvalid_a <= 1'b0;
      if (!rst_n) begin
         lat_a <= 2'd0;
      end else begin
         if (lat_a != 2'd0) begin
            lat_a <= lat_a - 2'd1;
            if (lat_a == 2'd1) begin
               mvalid_a <= 1'b1;
               rdata    <= word_of(paddr_a - mbase_a);
            end
         end
         if (mem_read && !waitreq) begin
            lat_a   <= 2'd2;
            paddr_a <= mem_address;
            if (exp_addr_a.size() == 0) chk("a_unexpected_read", {32'd0, mem_address}, 64'hFFFF_FFFF_FFFF_FFFF);
            else chk("a_read_addr", {32'd0, mem_address}, {32'd0, exp_addr_a.pop_front()});
         end
      end
   end

   // Memory model B: never waits, same latency.
   always @(posedge clk) begin
      mvalid_b <= 1'b0;
      if (!rst_n) begin
         lat_b <= 2'd0;
      end else begin
         if (lat_b != 2'd0) begin
            lat_b <= lat_b - 2'd1;
            if (lat_b == 2'd1) begin
               mvalid_b <= 1'b1;
               rdata_b  <= word_of(paddr_b - mbase_b);
            end
         end
         if (read_b) begin
            lat_b   <= 2'd2;
            paddr_b <= addr_b;
            if (exp_addr_b.size() == 0) chk("b_unexpected_read", {32'd0, addr_b}, 64'hFFFF_FFFF_FFFF_FFFF);
            else chk("b_read_addr", {32'd0, addr_b}, {32'd0, exp_addr_b.pop_front()});
         end
      end
   end

   // Write scoreboards, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (fifo_wr != 9'd0) begin
            int idx;
            idx = 0;
            for (int i = 0; i < 9; i++) if (fifo_wr[i]) idx = i;
            nwr_a++;
            chk("a_wr_onehot", {63'd0, $onehot(fifo_wr)}, 64'd1);
            if (exp_wr_a.size() == 0) begin
               chk("a_unexpected_write", {55'd0, fifo_wr}, 64'd0);
            end else begin
               wr_t e;
               e = exp_wr_a.pop_front();
               chk("a_wr_fifo", 64'(idx), 64'(e.idx));
               chk("a_wr_data", {56'd0, fifo_data}, {56'd0, e.data});
            end
            if (idx == 0 && !seen0) begin first0 = fifo_data; seen0 = 1'b1; end
            if (idx == 8) last8 = fifo_data;
         end
         if (fifo_full != 9'd0) chk("a_wr_while_full", {55'd0, fifo_wr}, 64'd0);
         if (wr_b != 2'd0) begin
            nwr_b++;
            if (exp_wr_b.size() == 0) begin
               chk("b_unexpected_write", {62'd0, wr_b}, 64'd0);
            end else begin
               wr_t e;
               e = exp_wr_b.pop_front();
               chk("b_wr_fifo", {62'd0, wr_b}, 64'(1 << e.idx));
               chk("b_wr_data", {56'd0, data_b}, {56'd0, e.data});
            end
         end
      end
   end

   task automatic push_a(input logic [31:0] base);
      mbase_a = base;
      nwr_a   = 0;
      seen0   = 1'b0;
      for (int k = 0; k < 9; k++) begin
         exp_addr_a.push_back(base + 32'(k));
         for (int e = 0; e < 8; e++) exp_wr_a.push_back('{k, exp_byte(k, e, 1, 8)});
      end
   endtask

   task automatic start_a(input logic [31:0] base);
      @(negedge clk);
      base_addr = base;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
   endtask

   // Run until done (bounded); optionally stall one FIFO and poke start mid-run.
   task automatic wait_done_a(input string name, input int stall_fifo, input int stall_n, input bit poke);
      int  left;
      bit  stalled;
      left    = 0;
      stalled = 1'b0;
      for (int it = 1; it <= 3000 && !done; it++) begin
         @(posedge clk);
         #1;
         if (stall_fifo >= 0) begin
            if (left > 0) begin
               left--;
               if (left == 0) fifo_full = 9'd0;
            end else if (!stalled && fifo_wr[stall_fifo]) begin
               fifo_full[stall_fifo] = 1'b1;
               left    = stall_n;
               stalled = 1'b1;
            end
         end
         if (poke && it == 10) begin
            start     = 1'b1;
            base_addr = 32'hDEAD_0000;
         end else begin
            start = 1'b0;
         end
      end
      fifo_full = 9'd0;
      chk({name, "_done"}, {63'd0, done}, 64'd1);
      if (stall_fifo >= 0) chk({name, "_stall_seen"}, {63'd0, stalled}, 64'd1);
   endtask

   task automatic end_checks_a(input string name, input int exp_writes);
      @(negedge clk);
      chk({name, "_writes"}, 64'(nwr_a), 64'(exp_writes));
      chk({name, "_wr_left"}, 64'(exp_wr_a.size()), 64'd0);
      chk({name, "_rd_left"}, 64'(exp_addr_a.size()), 64'd0);
      chk({name, "_busy"}, {63'd0, busy}, 64'd0);
   endtask

   vec_t vecs[3];

   initial begin
      vecs[0] = '{32'h0000_0100, -1, 0, 72, 1'b1};
      vecs[1] = '{32'h0000_0100,  2, 5, 72, 1'b1};
      vecs[2] = '{32'hFFFF_FFFC,  8, 3, 72, 1'b1};

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; waitreq = 1'b0; stray_v = 1'b0;
      base_addr = 32'd0; fifo_full = 9'd0; nwr_a = 0; nwr_b = 0; seen0 = 1'b0;
      start_b = 1'b0; abort_b = 1'b0; base_b = 32'd0; full_b = 2'd0; mbase_b = 32'd0;
      mbase_a = 32'd0; first0 = 8'd0; last8 = 8'd0;
      repeat (3) @(negedge clk);
      chk("rst_mem_read", {63'd0, mem_read}, 64'd0);
      chk("rst_addr", {32'd0, mem_address}, 64'd0);
      chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
      chk("rst_fifo_wr_data", {47'd0, fifo_wr, fifo_data}, 64'd0);
      rst_n = 1'b1;

      // Table-driven full fills.
      foreach (vecs[i]) begin
         push_a(vecs[i].base);
         start_a(vecs[i].base);
         wait_done_a($sformatf("vec%0d", i), vecs[i].stall_fifo, vecs[i].stall_n, i == 1);
         chk($sformatf("vec%0d_done_val", i), {63'd0, done}, {63'd0, vecs[i].exp_done});
         end_checks_a($sformatf("vec%0d", i), vecs[i].exp_writes);
         if (i == 0) begin
            chk("vec0_fifo0_first", {56'd0, first0}, 64'h01);
            chk("vec0_fifo8_last", {56'd0, last8}, 64'h48);
         end
      end

      // done holds in IDLE; abort in IDLE is ignored.
      @(negedge clk) abort = 1'b1;
      repeat (2) @(negedge clk);
      abort = 1'b0;
      @(negedge clk);
      chk("idle_abort_busy", {63'd0, busy}, 64'd0);
      chk("idle_done_held", {63'd0, done}, 64'd1);

      // waitrequest held 3 cycles on the first request.
      push_a(32'h100);
      waitreq = 1'b1;
      start_a(32'h100);
      chk("start_clears_done", {63'd0, done}, 64'd0);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         chk($sformatf("wreq_read_c%0d", i), {63'd0, mem_read}, 64'd1);
         chk($sformatf("wreq_addr_c%0d", i), {32'd0, mem_address}, 64'h100);
      end
      waitreq = 1'b0;
      @(negedge clk);
      chk("wreq_read_dropped", {63'd0, mem_read}, 64'd0);
      wait_done_a("wreq", -1, 0, 1'b0);
      end_checks_a("wreq", 72);

      // Abort in WAIT: DRAIN until the response, then IDLE with no writes.
      push_a(32'h100);
      start_a(32'h100);
      chk("abort_req_read", {63'd0, mem_read}, 64'd1);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_drain_busy", {63'd0, busy}, 64'd1);
      begin
         int n;
         n = 0;
         while (!rvalid && n < 20) begin @(negedge clk); n++; end
         chk("abort_rvalid_seen", {63'd0, rvalid}, 64'd1);
      end
      @(negedge clk);
      chk("abort_idle", {63'd0, busy}, 64'd0);
      chk("abort_done", {63'd0, done}, 64'd0);
      repeat (4) @(negedge clk);
      chk("abort_no_writes", 64'(nwr_a), 64'd0);
      exp_wr_a.delete();
      exp_addr_a.delete();
      push_a(32'h100);
      start_a(32'h100);
      wait_done_a("after_abort", -1, 0, 1'b0);
      end_checks_a("after_abort", 72);

      // Reset asserted mid-UNPACK, then a stray response.
      push_a(32'h100);
      start_a(32'h100);
      begin
         int n;
         n = 0;
         while (fifo_wr == 9'd0 && n < 50) begin @(negedge clk); n++; end
         chk("rst_mid_reached_unpack", {63'd0, fifo_wr != 9'd0}, 64'd1);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_read_addr", {31'd0, mem_read, mem_address}, 64'd0);
      chk("rst_mid_wr_data", {47'd0, fifo_wr, fifo_data}, 64'd0);
      chk("rst_mid_busy_done", {62'd0, busy, done}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_wr_a.delete();
      exp_addr_a.delete();
      nwr_a = 0;
      @(negedge clk) stray_v = 1'b1;
      @(negedge clk) stray_v = 1'b0;
      repeat (4) @(negedge clk);
      chk("stray_no_write", 64'(nwr_a), 64'd0);
      chk("stray_busy", {63'd0, busy}, 64'd0);
      push_a(32'h200);
      start_a(32'h200);
      wait_done_a("after_rst", -1, 0, 1'b0);
      end_checks_a("after_rst", 72);

      // Instance B: DEPTH=12 spans two words per FIFO, upper half of word 2 dropped.
      mbase_b = 32'h40;
      nwr_b   = 0;
      for (int k = 0; k < 2; k++) begin
         exp_addr_b.push_back(32'h40 + 32'(2 * k));
         exp_addr_b.push_back(32'h40 + 32'(2 * k + 1));
         for (int e = 0; e < 12; e++) exp_wr_b.push_back('{k, exp_byte(k, e, 2, 8)});
      end
      @(negedge clk);
      base_b  = 32'h40;
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      begin
         int n;
         n = 0;
         while (!done_b && n < 500) begin @(negedge clk); n++; end
      end
      chk("b_done", {63'd0, done_b}, 64'd1);
      chk("b_writes", 64'(nwr_b), 64'd24);
      chk("b_wr_left", 64'(exp_wr_b.size()), 64'd0);
      chk("b_rd_left", 64'(exp_addr_b.size()), 64'd0);
      chk("b_busy", {63'd0, busy_b}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
